led_frame_sink: RTL and testbench
=================================

Name: led_frame_sink

Overview:
- AXI4-Lite write-only responder at the LED-driver end of the car_to_p master write path.
- Accepts 32-bit words of polar RGB frame data into a double-buffered frame store.
- A write to the control register (or, optionally, the last frame word) swaps buffers.
- The LED arm driver reads the displayed buffer through a simple synchronous read port.

Parameters:
- NO_ARM_LED, 32, LEDs per arm
- NO_DELTA_INTERVALS, 16, angular slices per revolution
- RGB_SIZE, 8, bits per LED entry
- DATA_WIDTH, 32, AXI data width; fixed at 32
- ADDR_WIDTH, 32, AXI address width
- CTRL_OFFSET, 'h800, byte offset of the commit/control register

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address (byte)
- s_axi_awvalid  in  1  address valid
- s_axi_awready  out  1  address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  data valid
- s_axi_wready  out  1  data ready
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  response valid
- s_axi_bready  in  1  response ready
- rd_addr  in  WORD_IDX_W  word index into the display buffer
- rd_en  in  1  read strobe
- rd_data  out  DATA_WIDTH  display word, 1-cycle latency
- frame_swap  out  1  one-cycle pulse when the buffers swap
- frame_count  out  16  number of committed frames, wraps modulo 2^16

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Derived values:
  - FRAME_WORDS = NO_DELTA_INTERVALS*NO_ARM_LED*RGB_SIZE/32, which is 128 at defaults.
  - WORD_IDX_W = clog2(FRAME_WORDS).
  - Address decode uses awaddr[11:0] only; bits [1:0] are ignored.
- Reset values: awready=1, wready=1, bvalid=0, bresp=00, rd_data=0, frame_swap=0, frame_count=0, display select=0, write buffer=1. Buffer RAM contents are not reset.
- Reset mid-transaction drops any latched AW/W and any pending B response. The master must reissue.
- Write-channel FSM (AW and W may arrive in either order or in the same cycle):
  - IDLE: awready and wready are high. Each handshake latches its payload and drops its ready. Once both are latched, go to COMMIT.
  - COMMIT (1 cycle): decode and perform the write, set bvalid=1, go to RESP.
  - RESP: hold bvalid and bresp until bready. On the handshake cycle bvalid drops, then awready and wready return high, and the FSM returns to IDLE.
- Address decode:
  - Offset < FRAME_WORDS*4: data word. Write bytes whose wstrb bit is set into the write buffer at index offset>>2. bresp=OKAY.
  - Offset == CTRL_OFFSET: control. If wdata[0]=1, swap buffers; wstrb is ignored. bresp=OKAY.
  - Any other offset: discard, bresp=SLVERR.
- Swap:
  - Display select toggles on the clock edge ending COMMIT.
  - frame_swap pulses high for the following cycle.
  - frame_count increments with the swap.
  - The new write buffer's contents are stale until the master overwrites them.
- Read port:
  - rd_data registers RAM[display][rd_addr] when rd_en=1, otherwise holds.
  - A read issued in the same cycle as the swap edge returns the old display buffer.
  - rd_addr >= FRAME_WORDS returns 0.
- A sender that never raises bready stalls all further writes; no timeout is applied.

Optional Feature:
- Macro: LED_SINK_AUTO_COMMIT_EN.
- Defined: a data write to word index FRAME_WORDS-1 with wstrb=4'hF also performs the swap in the same COMMIT cycle. A control write still swaps.
- Undefined: only a control write with wdata[0]=1 swaps.

Decomposition:
- Package led_sink_pkg:
  - constants FRAME_WORDS, WORD_IDX_W, CTRL_OFFSET
  - bresp codes RESP_OKAY and RESP_SLVERR
  - write FSM state enum with IDLE, COMMIT, RESP
- Sub-module led_frame_dpram:
  - 2×FRAME_WORDS×32 storage
  - one write port with byte enables and buffer-select bit
  - one registered read port with buffer-select bit

Test Plan:
- AW and W in the same cycle at addr 'h0, data 'hA1B2C3D4, strobe 'hF, then CTRL write of 1 -> bvalid after 2 cycles with bresp=00; frame_swap pulses once; frame_count=1; rd_addr=0 returns 'hA1B2C3D4.
- W arrives 3 cycles before AW at addr 'h4 with strobe 'h3 and data 'hFFFF_1234 over old 'h5555_5555 -> word 1 = 'h5555_1234 after swap; only one B response.
- bready held low for 5 cycles -> bvalid, bresp, awready=0 and wready=0 are all stable throughout; a second AW is not accepted until the B handshake completes.
- Write to addr 'h400 -> bresp=10; no RAM word changes; frame_count unchanged.
- rd_en=1 in the same cycle as the swap edge -> returns the old-buffer word; the next read returns the new-buffer word.
- reset asserted while AW is latched and W is pending -> bvalid=0, awready=1, wready=1, frame_count=0 the next cycle. With LED_SINK_AUTO_COMMIT_EN defined, a full-strobe write to word 127 -> frame_swap pulses with no CTRL write.

Source files
------------

// File: rtl/led_frame_sink_pkg.sv
// Shared constants, response codes and write-FSM state type for the LED frame sink.
package led_sink_pkg;

   localparam int unsigned FRAME_WORDS = 16 * 32 * 8 / 32;
   localparam int unsigned WORD_IDX_W  = $clog2(FRAME_WORDS);
   localparam logic [11:0] CTRL_OFFSET = 12'h800;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      COMMIT,
      RESP
   } wr_state_e;

endpackage

// File: rtl/led_frame_sink_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the frame sender and the sink.
interface led_frame_sink_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/led_frame_dpram.sv
// Two-bank frame store: byte-enabled write port and registered read port, each with a bank select.
module led_frame_dpram
   import led_sink_pkg::*;
#(
   parameter int unsigned WORDS  = FRAME_WORDS,
   parameter int unsigned IDX_W  = WORD_IDX_W,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                we,
   input  logic                wr_buf,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_en,
   input  logic                rd_buf,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic [DATA_W-1:0]   rd_data
);

   logic [DATA_W-1:0] mem [2*WORDS];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            if (wr_be[b]) mem[{wr_buf, wr_idx}][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Indices past the frame read as zero rather than aliasing into the other bank.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (32'(rd_idx) < WORDS) ? mem[{rd_buf, rd_idx}] : '0;
      end
   end

endmodule

// File: rtl/led_frame_sink.sv
// AXI4-Lite write-only frame sink feeding a double-buffered LED frame store.
// Build option: LED_SINK_AUTO_COMMIT_EN also swaps on a full-strobe write of the last frame word.
module led_frame_sink
   import led_sink_pkg::*;
#(
   parameter int unsigned NO_ARM_LED         = 32,
   parameter int unsigned NO_DELTA_INTERVALS = 16,
   parameter int unsigned RGB_SIZE           = 8,
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned ADDR_WIDTH         = 32,
   parameter logic [11:0] CTRL_OFFSET        = 12'h800
) (
   input  logic                  clock,
   input  logic                  reset,
   led_frame_sink_if.slave       s_axi,
   input  logic [$clog2(NO_DELTA_INTERVALS*NO_ARM_LED*RGB_SIZE/32)-1:0] rd_addr,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  frame_swap,
   output logic [15:0]           frame_count
);

   localparam int unsigned N_WORDS = NO_DELTA_INTERVALS * NO_ARM_LED * RGB_SIZE / 32;
   localparam int unsigned IDX_W   = $clog2(N_WORDS);

   wr_state_e             state;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [9:0]            aw_off_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            wstrb_q;
   logic                  disp_sel;

   logic                  is_data;
   logic                  is_ctrl;
   logic                  do_swap;
   logic                  ram_we;
   logic                  unused_addr_bits;

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;

   assign unused_addr_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:12], s_axi.awaddr[1:0]};

   always_comb begin
      is_data = 32'({aw_off_q, 2'b00}) < N_WORDS * 4;
      is_ctrl = aw_off_q == CTRL_OFFSET[11:2];
      do_swap = is_ctrl && wdata_q[0];
`ifdef LED_SINK_AUTO_COMMIT_EN
      if (is_data && aw_off_q[IDX_W-1:0] == IDX_W'(N_WORDS - 1) && wstrb_q == 4'hF) do_swap = 1'b1;
`endif
      ram_we = (state == COMMIT) && is_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         awready_q   <= 1'b1;
         wready_q    <= 1'b1;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         aw_off_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         disp_sel    <= 1'b0;
         frame_swap  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_swap <= 1'b0;
         unique case (state)
            // A ready that is already low means that channel's payload is latched.
            IDLE: begin
               if (s_axi.awvalid && awready_q) begin
                  aw_off_q  <= s_axi.awaddr[11:2];
                  awready_q <= 1'b0;
               end
               if (s_axi.wvalid && wready_q) begin
                  wdata_q  <= s_axi.wdata;
                  wstrb_q  <= s_axi.wstrb;
                  wready_q <= 1'b0;
               end
               if ((!awready_q || s_axi.awvalid) && (!wready_q || s_axi.wvalid)) state <= COMMIT;
            end
            COMMIT: begin
               bvalid_q <= 1'b1;
               bresp_q  <= (is_data || is_ctrl) ? RESP_OKAY : RESP_SLVERR;
               if (do_swap) begin
                  disp_sel    <= ~disp_sel;
                  frame_swap  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
               end
               state <= RESP;
            end
            RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   led_frame_dpram #(
      .WORDS  (N_WORDS),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_WIDTH)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .we      (ram_we),
      .wr_buf  (~disp_sel),
      .wr_idx  (aw_off_q[IDX_W-1:0]),
      .wr_data (wdata_q),
      .wr_be   (wstrb_q),
      .rd_en   (rd_en),
      .rd_buf  (disp_sel),
      .rd_idx  (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_led_frame_sink.sv
// Scoreboard bench for led_frame_sink: directed writes push expected B/read responses, monitors pop and compare.
module tb_led_frame_sink;
   import led_sink_pkg::*;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic [WORD_IDX_W-1:0] rd_addr;
   logic                  rd_en;
   logic [31:0]           rd_data;
   logic                  frame_swap;
   logic [15:0]           frame_count;

   led_frame_sink_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

   led_frame_sink dut (
      .clock       (clock),
      .reset       (reset),
      .s_axi       (s_axi),
      .rd_addr     (rd_addr),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .frame_swap  (frame_swap),
      .frame_count (frame_count)
   );

   always #5 clock = ~clock;

   int          n_pass  = 0;
   int          n_total = 0;
   int          b_cnt   = 0;
   int          swap_cnt = 0;
   logic [1:0]  b_q[$];
   logic [31:0] rd_q[$];
   logic        rd_pend = 1'b0;
   time         t_hs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clock) rd_pend <= rd_en;

   always @(negedge clock) begin
      if (s_axi.bvalid && s_axi.bready) begin
         b_cnt++;
         check("b_expected_pending", 32'(b_q.size() > 0), 32'd1);
         if (b_q.size() > 0) check("bresp", 32'(s_axi.bresp), 32'(b_q.pop_front()));
      end
      if (frame_swap) swap_cnt++;
      if (rd_pend) begin
         check("rd_expected_pending", 32'(rd_q.size() > 0), 32'd1);
         if (rd_q.size() > 0) check("rd_data", rd_data, rd_q.pop_front());
      end
   end

   task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_lag, input int w_lag, input logic [1:0] exp_resp);
      time t_aw, t_w;
      bit  ok_aw, ok_w;
      ok_aw = 1'b0;
      ok_w  = 1'b0;
      b_q.push_back(exp_resp);
      fork
         begin
            repeat (aw_lag) @(posedge clock);
            #1 s_axi.awaddr = addr;
            s_axi.awvalid = 1'b1;
            for (int n = 0; n < 40; n++) begin
               @(posedge clock);
               if (s_axi.awready) begin ok_aw = 1'b1; break; end
            end
            t_aw = $time;
            #1 s_axi.awvalid = 1'b0;
         end
         begin
            repeat (w_lag) @(posedge clock);
            #1 s_axi.wdata = data;
            s_axi.wstrb  = strb;
            s_axi.wvalid = 1'b1;
            for (int n = 0; n < 40; n++) begin
               @(posedge clock);
               if (s_axi.wready) begin ok_w = 1'b1; break; end
            end
            t_w = $time;
            #1 s_axi.wvalid = 1'b0;
         end
      join
      check("aw_handshake", 32'(ok_aw), 32'd1);
      check("w_handshake", 32'(ok_w), 32'd1);
      t_hs = (t_aw > t_w) ? t_aw : t_w;
   endtask

   task automatic wait_b(input bit chk_lat);
      bit seen = 1'b0;
      bit done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clock);
         if (s_axi.bvalid && !seen) begin
            seen = 1'b1;
            if (chk_lat) check("b_latency", 32'(($time - t_hs + 5) / 10), 32'd2);
         end
         if (s_axi.bvalid && s_axi.bready) done = 1'b1;
      end
      check("b_handshake_done", 32'(done), 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [1:0] exp_resp);
      issue(addr, data, strb, 0, 0, exp_resp);
      wait_b(1'b1);
   endtask

   task automatic rd(input logic [WORD_IDX_W-1:0] a, input logic [31:0] e);
      rd_addr = a;
      rd_en   = 1'b1;
      rd_q.push_back(e);
      @(posedge clock);
      #1 rd_en = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_frames;
      int exp_swaps;
      int bc;
      bit ok;

      s_axi.awaddr  = '0;
      s_axi.awvalid = 1'b0;
      s_axi.wdata   = '0;
      s_axi.wstrb   = '0;
      s_axi.wvalid  = 1'b0;
      s_axi.bready  = 1'b1;
      rd_addr       = '0;
      rd_en         = 1'b0;
      exp_frames    = 0;
      exp_swaps     = 0;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_awready", 32'(s_axi.awready), 32'd1);
      check("rst_wready", 32'(s_axi.wready), 32'd1);
      check("rst_bvalid", 32'(s_axi.bvalid), 32'd0);
      check("rst_bresp", 32'(s_axi.bresp), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_frame_swap", 32'(frame_swap), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      @(posedge clock);
      #1;

      // Same-cycle AW/W, then commit and read back
      write(32'h0, 32'hA1B2_C3D4, 4'hF, RESP_OKAY);
      write(32'h800, 32'h1, 4'hF, RESP_OKAY);
      exp_frames++; exp_swaps++;
      check("t1_frame_count", 32'(frame_count), 32'(exp_frames));
      check("t1_swap_pulses", 32'(swap_cnt), 32'(exp_swaps));
      rd(0, 32'hA1B2_C3D4);

      // W three cycles ahead of AW, partial strobe over an existing word
      write(32'h4, 32'h5555_5555, 4'hF, RESP_OKAY);
      bc = b_cnt;
      issue(32'h4, 32'hFFFF_1234, 4'h3, 3, 0, RESP_OKAY);
      wait_b(1'b1);
      repeat (3) @(posedge clock);
      #1 check("t2_single_b", 32'(b_cnt), 32'(bc + 1));
      write(32'h800, 32'h1, 4'hF, RESP_OKAY);
      exp_frames++; exp_swaps++;
      check("t2_frame_count", 32'(frame_count), 32'(exp_frames));
      rd(1, 32'h5555_1234);

      // bready held low: response and readies stay put, a new AW waits
      s_axi.bready = 1'b0;
      issue(32'h8, 32'h0BAD_F00D, 4'hF, 0, 0, RESP_OKAY);
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clock);
         ok = s_axi.bvalid;
      end
      check("t3_bvalid_seen", 32'(ok), 32'd1);
      @(posedge clock);
      #1 s_axi.awaddr = 32'hC;
      s_axi.awvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("t3_bvalid_hold", 32'(s_axi.bvalid), 32'd1);
         check("t3_bresp_hold", 32'(s_axi.bresp), 32'(RESP_OKAY));
         check("t3_awready_low", 32'(s_axi.awready), 32'd0);
         check("t3_wready_low", 32'(s_axi.wready), 32'd0);
      end
      @(posedge clock);
      #1 s_axi.awvalid = 1'b0;
      s_axi.bready = 1'b1;
      wait_b(1'b0);
      write(32'hC, 32'h600D_CAFE, 4'hF, RESP_OKAY);

      // Decode errors, non-committing control write, low address bits ignored
      write(32'h400, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR);
      check("t4_count_after_slverr", 32'(frame_count), 32'(exp_frames));
      write(32'h200, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR);
      write(32'h800, 32'h0, 4'hF, RESP_OKAY);
      check("t4_ctrl0_no_swap", 32'(swap_cnt), 32'(exp_swaps));
      write(32'h802, 32'h1, 4'h0, RESP_OKAY);
      exp_frames++; exp_swaps++;
      check("t4_frame_count", 32'(frame_count), 32'(exp_frames));
      check("t4_swap_pulses", 32'(swap_cnt), 32'(exp_swaps));
      rd(0, 32'hA1B2_C3D4);
      rd(2, 32'h0BAD_F00D);
      rd(3, 32'h600D_CAFE);

      // Read on the swap edge sees the old bank, the next read the new one
      write(32'h14, 32'h2222_2222, 4'hF, RESP_OKAY);
      write(32'h800, 32'h1, 4'hF, RESP_OKAY);
      exp_frames++; exp_swaps++;
      write(32'h14, 32'h3333_3333, 4'hF, RESP_OKAY);
      issue(32'h800, 32'h1, 4'hF, 0, 0, RESP_OKAY);
      rd_addr = 5;
      rd_en   = 1'b1;
      rd_q.push_back(32'h2222_2222);
      fork
         wait_b(1'b1);
         begin
            @(posedge clock);
            #1 rd_q.push_back(32'h3333_3333);
            @(posedge clock);
            #1 rd_en = 1'b0;
         end
      join
      exp_frames++; exp_swaps++;
      @(posedge clock);
      #1 check("t5_frame_count", 32'(frame_count), 32'(exp_frames));

      // Reset with AW latched and W still pending
      s_axi.awaddr  = 32'h10;
      s_axi.awvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clock);
         if (s_axi.awready) begin ok = 1'b1; break; end
      end
      check("t6_aw_hs", 32'(ok), 32'd1);
      #1 s_axi.awvalid = 1'b0;
      @(negedge clock);
      check("t6_awready_latched", 32'(s_axi.awready), 32'd0);
      check("t6_wready_open", 32'(s_axi.wready), 32'd1);
      bc = b_cnt;
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("t6_bvalid", 32'(s_axi.bvalid), 32'd0);
      check("t6_awready", 32'(s_axi.awready), 32'd1);
      check("t6_wready", 32'(s_axi.wready), 32'd1);
      check("t6_frame_count", 32'(frame_count), 32'd0);
      check("t6_rd_data", rd_data, 32'd0);
      exp_frames = 0;
      repeat (4) @(negedge clock);
      check("t6_no_late_b", 32'(b_cnt), 32'(bc));
      check("t6_no_swap", 32'(swap_cnt), 32'(exp_swaps));
      @(posedge clock);
      #1;

      // Last frame word: partial strobe never swaps; full strobe swaps only with auto-commit
      write(32'h1FC, 32'hAAAA_AAAA, 4'h7, RESP_OKAY);
      check("t7_partial_no_swap", 32'(swap_cnt), 32'(exp_swaps));
      write(32'h1FC, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
`ifdef LED_SINK_AUTO_COMMIT_EN
      exp_frames++; exp_swaps++;
      check("t7_auto_swap", 32'(swap_cnt), 32'(exp_swaps));
      check("t7_auto_count", 32'(frame_count), 32'(exp_frames));
      rd(127, 32'hCAFE_F00D);
      write(32'h800, 32'h1, 4'hF, RESP_OKAY);
      exp_frames++; exp_swaps++;
      check("t7_ctrl_still_swaps", 32'(frame_count), 32'(exp_frames));
`else
      check("t7_no_auto_swap", 32'(swap_cnt), 32'(exp_swaps));
      check("t7_no_auto_count", 32'(frame_count), 32'(exp_frames));
      write(32'h800, 32'h1, 4'hF, RESP_OKAY);
      exp_frames++; exp_swaps++;
      check("t7_ctrl_count", 32'(frame_count), 32'(exp_frames));
      rd(127, 32'hCAFE_F00D);
`endif

      repeat (3) @(posedge clock);
      #1;
      check("end_b_queue_empty", 32'(b_q.size()), 32'd0);
      check("end_rd_queue_empty", 32'(rd_q.size()), 32'd0);
      check("end_swap_total", 32'(swap_cnt), 32'(exp_swaps));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
